// File: rtl/regfile_writeback_unit.sv
// regfile_writeback_unit
//   Sole driver of the RegisterFile write port (rd / WriteData / RegWrite).
//   After reset it sweeps every register to zero, then retires writeback
//   requests from a small in-order FIFO at a rate of at most one per cycle.
//   Optional feature macro: WB_BYPASS_EN adds two combinational read-bypass
//   ports that search pending writes (newest first).
module regfile_writeback_unit #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_W-1:0]           req_rd,
    input  logic [DATA_W-1:0]           req_data,
    input  logic                        wb_stall,
    output logic [ADDR_W-1:0]           rd,
    output logic [DATA_W-1:0]           WriteData,
    output logic                        RegWrite,
    output logic                        init_done,
    output logic [$clog2(FIFO_DEPTH):0] pending_count
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]           byp_rs1,
    input  logic [ADDR_W-1:0]           byp_rs2,
    output logic                        byp_hit1,
    output logic                        byp_hit2,
    output logic [DATA_W-1:0]           byp_data1,
    output logic [DATA_W-1:0]           byp_data2
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   clr_idx_reg, clr_idx_next;

    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [ADDR_W-1:0]   fifo_rd_mem   [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data_mem [FIFO_DEPTH];

    logic [ADDR_W-1:0]   rd_reg, rd_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic                we_reg, we_next;
    logic                init_done_reg;

    logic                push, pop;

    // Readiness only looks at the current occupancy; a same-cycle pop does not help.
    assign req_ready     = init_done_reg && (count_reg < DEPTH_C);
    assign rd            = rd_reg;
    assign WriteData     = wdata_reg;
    assign RegWrite      = we_reg;
    assign init_done     = init_done_reg;
    assign pending_count = count_reg;

    // State register and sweep index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_CLEAR;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    // Next state, FIFO push/pop decisions and next write-port values.
    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        rd_next      = rd_reg;
        wdata_next   = wdata_reg;
        we_next      = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                // Sweep ignores wb_stall: nothing else can own the port yet.
                we_next      = 1'b1;
                rd_next      = clr_idx_reg;
                wdata_next   = '0;
                clr_idx_next = clr_idx_reg + ADDR_W'(1);
                if (clr_idx_reg == LAST_IDX) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Writes to register 0 are handshaken but never stored.
                push = req_valid && req_ready && (req_rd != '0);
                pop  = (count_reg != '0) && !wb_stall;
                if (pop) begin
                    we_next    = 1'b1;
                    rd_next    = fifo_rd_mem[rd_ptr_reg];
                    wdata_next = fifo_data_mem[rd_ptr_reg];
                end
            end
            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_mem[wr_ptr_reg]   <= req_rd;
            fifo_data_mem[wr_ptr_reg] <= req_data;
        end
    end

    // Registered write-port outputs and the sticky init-done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_reg        <= '0;
            wdata_reg     <= '0;
            we_reg        <= 1'b0;
            init_done_reg <= 1'b0;
        end else begin
            rd_reg        <= rd_next;
            wdata_reg     <= wdata_next;
            we_reg        <= we_next;
            init_done_reg <= init_done_reg | (state_reg == ST_RUN);
        end
    end

`ifdef WB_BYPASS_EN
    // Entries listed by age: slot 0 is the oldest (FIFO head).
    logic [ADDR_W-1:0]     slot_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0]     slot_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] slot_vld;
    logic [ADDR_W-1:0]     byp_rs    [2];

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] idx;
            assign idx            = rd_ptr_reg + PTR_W'(gi);
            assign slot_vld[gi]   = CNT_W'(gi) < count_reg;
            assign slot_rd[gi]    = fifo_rd_mem[idx];
            assign slot_data[gi]  = fifo_data_mem[idx];
        end

        assign byp_rs[0] = byp_rs1;
        assign byp_rs[1] = byp_rs2;

        for (gi = 0; gi < 2; gi++) begin : g_byp
            logic              hit;
            logic [DATA_W-1:0] data;
            // Oldest candidate first so newer matches overwrite older ones.
            always_comb begin
                hit  = 1'b0;
                data = '0;
                if (we_reg && (rd_reg == byp_rs[gi])) begin
                    hit  = 1'b1;
                    data = wdata_reg;
                end
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (slot_vld[i] && (slot_rd[i] == byp_rs[gi])) begin
                        hit  = 1'b1;
                        data = slot_data[i];
                    end
                end
                if (byp_rs[gi] == '0) begin
                    hit  = 1'b0;
                    data = '0;
                end
                if (state_reg == ST_CLEAR) begin
                    data = '0;
                end
            end
        end
    endgenerate

    assign byp_hit1  = g_byp[0].hit;
    assign byp_hit2  = g_byp[1].hit;
    assign byp_data1 = g_byp[0].data;
    assign byp_data2 = g_byp[1].data;
`endif

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// tb_regfile_writeback_unit
//   Scoreboard bench: the driver pushes the writes each accepted request
//   must eventually produce; a monitor on the falling edge pops and compares
//   every register-file write and the status outputs.
module tb_regfile_writeback_unit;

    localparam int DATA_W     = 64;
    localparam int ADDR_W     = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int NUM_REGS   = 32;
    localparam int MAXE       = 8192;

    bit                clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rd;
    logic [DATA_W-1:0] req_data;
    logic              wb_stall;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;
    logic              init_done;
    logic [2:0]        pending_count;
`ifdef WB_BYPASS_EN
    logic [ADDR_W-1:0] byp_rs1, byp_rs2;
    logic              byp_hit1, byp_hit2;
    logic [DATA_W-1:0] byp_data1, byp_data2;
`endif

    always #5 clk = ~clk;

    regfile_writeback_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rd(req_rd),
        .req_data(req_data),
        .wb_stall(wb_stall),
        .rd(rd),
        .WriteData(WriteData),
        .RegWrite(RegWrite),
        .init_done(init_done),
        .pending_count(pending_count)
`ifdef WB_BYPASS_EN
        ,
        .byp_rs1(byp_rs1),
        .byp_rs2(byp_rs2),
        .byp_hit1(byp_hit1),
        .byp_hit2(byp_hit2),
        .byp_data1(byp_data1),
        .byp_data2(byp_data2)
`endif
    );

    // Expected write: target, value, sweep flag, edge at which it was accepted.
    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        bit                clr;
        int                acc;
    } wb_t;

    wb_t               sb_q[$];
    bit                rst_hist   [MAXE];
    bit                stall_hist [MAXE];
    int                edge_cnt = 0;
    int                checks = 0;
    int                errors = 0;
    bit                model_ready = 1'b0;
    bit                sweep_done = 1'b0;
    int                sweep_done_edge = 0;
    bit                prev_rst = 1'b1;
    logic [ADDR_W-1:0] last_rd = '0;
    logic [DATA_W-1:0] last_wd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", name, edge_cnt, act, exp);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Apply inputs for the coming edge and record what the model expects from it.
    task automatic drive(input bit rst, input bit v, input logic [ADDR_W-1:0] r,
                         input logic [DATA_W-1:0] d, input bit st);
        int  e;
        wb_t w;
        @(negedge clk);
        #1;
        e = edge_cnt + 1;
        if (e >= MAXE) begin
            $display("FAIL edge_budget actual=%0d required<%0d", e, MAXE);
            $fatal(1, "edge budget exhausted");
        end
        reset     = rst;
        req_valid = v;
        req_rd    = r;
        req_data  = d;
        wb_stall  = st;
        rst_hist[e]   = rst;
        stall_hist[e] = st;
        if (rst) begin
            sb_q.delete();
            prev_rst = 1'b1;
        end else begin
            if (prev_rst) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    w.rd = ADDR_W'(i); w.data = '0; w.clr = 1'b1; w.acc = e - 1;
                    sb_q.push_back(w);
                end
                prev_rst = 1'b0;
            end
            if (v && model_ready && (r != '0)) begin
                w.rd = r; w.data = d; w.clr = 1'b0; w.acc = e;
                sb_q.push_back(w);
            end
        end
    endtask

    // Monitor: checks the state left by the most recent rising edge.
    always @(negedge clk) begin
        int  k;
        int  pend;
        bit  exp_we;
        bit  exp_init;
        wb_t w;
        k = edge_cnt;
        if (k > 0 && k < MAXE) begin
            if (rst_hist[k]) begin
                chk("rst_regwrite", RegWrite, 0);
                chk("rst_rd", rd, 0);
                chk("rst_wdata", WriteData, 0);
                chk("rst_init_done", init_done, 0);
                chk("rst_req_ready", req_ready, 0);
                chk("rst_pending", pending_count, 0);
                last_rd     = '0;
                last_wd     = '0;
                sweep_done  = 1'b0;
                model_ready = 1'b0;
            end else begin
                exp_we = 1'b0;
                if (sb_q.size() > 0) begin
                    if (sb_q[0].acc < k && (sb_q[0].clr || !stall_hist[k])) exp_we = 1'b1;
                end
                chk("regwrite", RegWrite, exp_we);
                if (exp_we) begin
                    w = sb_q.pop_front();
                    last_rd = w.rd;
                    last_wd = w.data;
                    $display("wb edge=%0d rd=%0d data=%h sweep=%0d", k, rd, WriteData, w.clr);
                    if (w.clr && (sb_q.size() == 0 || !sb_q[0].clr)) begin
                        sweep_done      = 1'b1;
                        sweep_done_edge = k;
                    end
                end
                chk("rd", rd, last_rd);
                chk("wdata", WriteData, last_wd);
                pend = 0;
                foreach (sb_q[i]) if (!sb_q[i].clr && sb_q[i].acc <= k) pend++;
                exp_init = sweep_done && (k > sweep_done_edge);
                chk("init_done", init_done, exp_init);
                chk("pending", pending_count, pend);
                model_ready = exp_init && (pend < FIFO_DEPTH);
                chk("req_ready", req_ready, model_ready);
            end
        end
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_rd = '0; req_data = '0; wb_stall = 1'b0;
`ifdef WB_BYPASS_EN
        byp_rs1 = '0; byp_rs2 = '0;
`endif
        rst_hist[1] = 1'b1;
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        // Sweep of all registers, then idle into RUN.
        for (int i = 0; i < 36; i++) drive(0, 0, 0, 0, 0);
        // Single write with one-cycle latency.
        drive(0, 1, 5, 64'hDEAD_BEEF, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
        // Write to register 0 is accepted and dropped.
        drive(0, 1, 0, 64'h1, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
        // Fill under stall, one refused request while full, then drain.
        for (int i = 1; i <= 4; i++) drive(0, 1, ADDR_W'(i), 64'(i + 9), 1);
        drive(0, 1, 9, 64'h99, 1);
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0);
`ifdef WB_BYPASS_EN
        byp_rs1 = 7; byp_rs2 = 0;
        drive(0, 1, 7, 64'hA, 1);
        drive(0, 1, 7, 64'hB, 1);
        drive(0, 0, 0, 0, 1);
        chk("byp_hit1", byp_hit1, 1);
        chk("byp_data1", byp_data1, 64'hB);
        chk("byp_hit2", byp_hit2, 0);
        chk("byp_data2", byp_data2, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
`endif
        // Reset with entries pending: they are discarded and the sweep restarts.
        for (int i = 1; i <= 3; i++) drive(0, 1, ADDR_W'(20 + i), 64'(100 + i), 1);
        drive(1, 0, 0, 0, 1);
        for (int i = 0; i < 40; i++) drive(0, 0, 0, 0, 0);
        // Randomized traffic with stalls and the occasional reset.
        for (int i = 0; i < 600; i++) begin
            bit                rst_r, v_r, st_r;
            logic [ADDR_W-1:0] r_r;
            logic [DATA_W-1:0] d_r;
            rst_r = ($urandom_range(0, 249) == 0);
            v_r   = ($urandom_range(0, 9) < 7);
            st_r  = ($urandom_range(0, 9) < 3);
            r_r   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            d_r   = {$urandom, $urandom};
            drive(rst_r, v_r, r_r, d_r, st_r);
        end
        for (int i = 0; i < 45; i++) drive(0, 0, 0, 0, 0);
        chk("drain_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
